// File: rtl/mem_port_arbiter.sv
// Purpose  : round-robin arbiter/sequencer sharing one memory port between
//            instruction fetch (i_*), data read (dr_*) and data write (dw_*).
// Latency  : grant 1 cycle after request seen in IDLE; response 1 cycle after m_rvalid.
// Backpres.: requests stay pending until *_gnt; m_req is held until m_gnt;
//            REQ+WAIT is bounded by TIMEOUT cycles, then the requester gets *_err.
// Ports    : clk/rst (async active-high), three requester ports, the m_* memory
//            port and busy (state != IDLE). Every output comes from a register.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    // data read
    input  logic            dr_req,
    input  logic [AW-1:0]   dr_addr,
    output logic            dr_gnt,
    output logic            dr_rvalid,
    output logic [DW-1:0]   dr_rdata,
    output logic            dr_err,
    // data write
    input  logic            dw_req,
    input  logic [AW-1:0]   dw_addr,
    input  logic [DW-1:0]   dw_wdata,
    input  logic [DW/8-1:0] dw_be,
    output logic            dw_gnt,
    output logic            dw_done,
    output logic            dw_err,
    // memory port
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // requester index: 0 = fetch, 1 = data read, 2 = data write
    localparam logic [1:0] R_I  = 2'd0;
    localparam logic [1:0] R_DR = 2'd1;
    localparam logic [1:0] R_DW = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [BW-1:0] m_be_q, m_be_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    resp_q, resp_d;
    logic [2:0]    err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [2:0]    req_vec;
    logic          win_vld;
    logic [1:0]    win;

    assign req_vec = {dw_req, dr_req, i_req};

    // Round-robin pick: scan starting at the requester after the last winner.
    always_comb begin
        logic [1:0] order [3];
        win_vld = 1'b0;
        win     = R_I;
        case (last_q)
            R_I:     begin order[0] = R_DR; order[1] = R_DW; order[2] = R_I;  end
            R_DR:    begin order[0] = R_DW; order[1] = R_I;  order[2] = R_DR; end
            default: begin order[0] = R_I;  order[1] = R_DR; order[2] = R_DW; end
        endcase
        for (int k = 0; k < 3; k++) begin
            if (!win_vld && req_vec[order[k]]) begin
                win_vld = 1'b1;
                win     = order[k];
            end
        end
    end

    always_comb begin
        logic finish;
        logic abort;
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        gnt_d     = '0;
        resp_d    = '0;
        err_d     = '0;
        rdata_d   = rdata_q;
        finish    = 1'b0;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // m_gnt/m_rvalid are ignored here, so late responses to an
                // aborted transaction never reach a requester.
                if (win_vld) begin
                    state_d      = S_REQ;
                    last_d       = win;
                    cnt_d        = '0;
                    m_req_d      = 1'b1;
                    gnt_d[win]   = 1'b1;
                    case (win)
                        R_I: begin
                            m_we_d    = 1'b0;
                            m_addr_d  = i_addr;
                            m_wdata_d = '0;
                            m_be_d    = '0;
                        end
                        R_DR: begin
                            m_we_d    = 1'b0;
                            m_addr_d  = dr_addr;
                            m_wdata_d = '0;
                            m_be_d    = '0;
                        end
                        default: begin
                            m_we_d    = 1'b1;
                            m_addr_d  = dw_addr;
                            m_wdata_d = dw_wdata;
                            m_be_d    = dw_be;
                        end
                    endcase
                end
            end
            // grant and response together complete straight out of REQ
            S_REQ:   finish = m_gnt & m_rvalid;
            S_WAIT:  finish = m_rvalid;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_REQ || state_q == S_WAIT) begin
            // a completion on the last allowed cycle wins over the timeout
            if (!finish && cnt_q == CNT_LAST) begin
                abort = 1'b1;
            end else if (!finish) begin
                cnt_d = cnt_q + CW'(1);
                if (state_q == S_REQ && m_gnt) begin
                    m_req_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
        end

        if (finish || abort) begin
            state_d        = S_IDLE;
            m_req_d        = 1'b0;
            resp_d[last_q] = 1'b1;
            err_d[last_q]  = abort;
            if (last_q != R_DW) begin
                rdata_d = abort ? '0 : m_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= R_DW;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            gnt_q     <= '0;
            resp_q    <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            gnt_q     <= gnt_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign i_gnt     = gnt_q[0];
    assign dr_gnt    = gnt_q[1];
    assign dw_gnt    = gnt_q[2];
    assign i_rvalid  = resp_q[0];
    assign dr_rvalid = resp_q[1];
    assign dw_done   = resp_q[2];
    assign i_err     = err_q[0];
    assign dr_err    = err_q[1];
    assign dw_err    = err_q[2];
    assign i_rdata   = rdata_q;
    assign dr_rdata  = rdata_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose  : self-checking bench for mem_port_arbiter (vector table, directed
//            corner sequences, random traffic against a transaction-level model).
// Latency  : n/a.  Backpressure: requesters hold req until gnt; memory is scripted/random.
module tb_mem_port_arbiter;

    localparam int TO_MAIN  = 16;
    localparam int TO_SHORT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, dr_req = 0, dw_req = 0;
    logic [31:0] i_addr = 0, dr_addr = 0, dw_addr = 0, dw_wdata = 0;
    logic [3:0]  dw_be = 0;
    logic        m_gnt = 0, m_rvalid = 0;
    logic [31:0] m_rdata = 0;

    logic        i_gnt, i_rvalid, i_err, dr_gnt, dr_rvalid, dr_err, dw_gnt, dw_done, dw_err;
    logic [31:0] i_rdata, dr_rdata, m_addr, m_wdata;
    logic        m_req, m_we, busy;
    logic [3:0]  m_be;

    logic        to_i_gnt, to_i_rvalid, to_i_err, to_dr_gnt, to_dr_rvalid, to_dr_err;
    logic        to_dw_gnt, to_dw_done, to_dw_err;
    logic [31:0] to_i_rdata, to_dr_rdata, to_m_addr, to_m_wdata;
    logic        to_m_req, to_m_we, to_busy;
    logic [3:0]  to_m_be;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO_MAIN)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_rvalid(dr_rvalid),
        .dr_rdata(dr_rdata), .dr_err(dr_err),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_be(dw_be),
        .dw_gnt(dw_gnt), .dw_done(dw_done), .dw_err(dw_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO_SHORT)) u_dut_to (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(to_i_gnt), .i_rvalid(to_i_rvalid),
        .i_rdata(to_i_rdata), .i_err(to_i_err),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(to_dr_gnt), .dr_rvalid(to_dr_rvalid),
        .dr_rdata(to_dr_rdata), .dr_err(to_dr_err),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_be(dw_be),
        .dw_gnt(to_dw_gnt), .dw_done(to_dw_done), .dw_err(to_dw_err),
        .m_req(to_m_req), .m_we(to_m_we), .m_addr(to_m_addr), .m_wdata(to_m_wdata),
        .m_be(to_m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(to_busy)
    );

    wire [2:0] gnt  = {dw_gnt, dr_gnt, i_gnt};
    wire [2:0] resp = {dw_done, dr_rvalid, i_rvalid};
    wire [2:0] errv = {dw_err, dr_err, i_err};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic quiet_inputs();
        i_req = 0; dr_req = 0; dw_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  req;
        logic        mg;
        logic        mv;
        logic [31:0] rd;
        logic [2:0]  gnt;
        logic [2:0]  resp;
        logic [31:0] rdata;
        logic        mreq;
        logic        busy;
        logic [31:0] maddr;
    } vec_t;

    vec_t tbl[12];

    // ---------------- reference model ----------------
    logic [2:0]  reqb;
    logic [31:0] addr_r[3];
    logic [31:0] wd_r;
    logic [3:0]  be_r;
    bit          md_active, md_acc;
    int          md_who, md_age, md_last;
    logic [2:0]  e_gnt, e_resp, e_err;
    logic [31:0] e_rdata, e_maddr, e_mwdata;
    logic [3:0]  e_mbe;
    logic        e_mreq, e_mwe, e_busy;

    task automatic model_reset();
        md_active = 0; md_acc = 0; md_who = 0; md_age = 0; md_last = 2;
        e_gnt = 0; e_resp = 0; e_err = 0; e_rdata = 0; e_maddr = 0; e_mwdata = 0;
        e_mbe = 0; e_mreq = 0; e_mwe = 0; e_busy = 0;
    endtask

    // Expected outputs after the next clock edge, from the inputs of this cycle.
    task automatic model_step();
        bit done;
        bit found;
        e_gnt = 0; e_resp = 0; e_err = 0;
        if (!md_active) begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (md_last + k) % 3;
                if (!found && reqb[idx]) begin
                    found = 1;
                    md_active = 1; md_who = idx; md_age = 0; md_acc = 0; md_last = idx;
                    e_gnt[idx] = 1'b1;
                    e_mreq = 1'b1;
                    e_maddr = addr_r[idx];
                    e_mwe = (idx == 2);
                    e_mwdata = wd_r;
                    e_mbe = be_r;
                end
            end
        end else begin
            done = md_acc ? m_rvalid : (m_gnt && m_rvalid);
            if (done || md_age == TO_MAIN - 1) begin
                e_resp[md_who] = 1'b1;
                e_err[md_who]  = !done;
                if (md_who != 2) e_rdata = done ? m_rdata : 32'h0;
                md_active = 0;
                e_mreq = 1'b0;
            end else begin
                if (!md_acc && m_gnt) begin
                    md_acc = 1;
                    e_mreq = 1'b0;
                end
                md_age++;
            end
        end
        e_busy = md_active;
    endtask

    initial begin
        int ngr;
        int exp_idx;
        int w;

        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        #1;
        chk("reset_u_outs", {gnt, resp, errv, m_req, m_we, busy, m_be}, 0);
        chk("reset_u_data", {i_rdata, dr_rdata}, 0);
        chk("reset_u_maddr", {m_addr, m_wdata}, 0);
        chk("reset_to_outs", {to_i_gnt, to_dr_gnt, to_dw_gnt, to_i_rvalid, to_dr_rvalid,
                              to_dw_done, to_i_err, to_dr_err, to_dw_err, to_m_req,
                              to_m_we, to_busy, to_m_be}, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table: single fetch, simultaneous grant+response ----------------
        tbl[0]  = '{3'b001, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 32'h0,        1'b1, 1'b1, 32'h100};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b1, 32'h100};
        tbl[2]  = '{3'b000, 1'b0, 1'b1, 32'hDEADBEEF, 3'b000, 3'b001, 32'hDEADBEEF, 1'b0, 1'b0, 32'h100};
        tbl[3]  = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 32'h100};
        tbl[4]  = '{3'b010, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 32'h0,        1'b1, 1'b1, 32'h200};
        tbl[5]  = '{3'b000, 1'b1, 1'b1, 32'hCAFEF00D, 3'b000, 3'b010, 32'hCAFEF00D, 1'b0, 1'b0, 32'h200};
        tbl[6]  = '{3'b001, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 32'h0,        1'b1, 1'b1, 32'h100};
        tbl[7]  = '{3'b000, 1'b0, 1'b1, 32'h5555AAAA, 3'b000, 3'b000, 32'h0,        1'b1, 1'b1, 32'h100};
        tbl[8]  = '{3'b000, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b1, 32'h100};
        tbl[9]  = '{3'b000, 1'b0, 1'b1, 32'h11111111, 3'b000, 3'b001, 32'h11111111, 1'b0, 1'b0, 32'h100};
        tbl[10] = '{3'b000, 1'b1, 1'b1, 32'h77777777, 3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 32'h100};
        tbl[11] = '{3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 32'h0,        1'b0, 1'b0, 32'h100};
        i_addr = 32'h100;
        dr_addr = 32'h200;
        for (int r = 0; r < 12; r++) begin
            {dw_req, dr_req, i_req} = tbl[r].req;
            m_gnt = tbl[r].mg; m_rvalid = tbl[r].mv; m_rdata = tbl[r].rd;
            tick();
            chk($sformatf("tbl%0d_gnt", r), gnt, tbl[r].gnt);
            chk($sformatf("tbl%0d_resp", r), resp, tbl[r].resp);
            chk($sformatf("tbl%0d_err", r), errv, 0);
            chk($sformatf("tbl%0d_mreq", r), m_req, tbl[r].mreq);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
            chk($sformatf("tbl%0d_maddr", r), m_addr, tbl[r].maddr);
            if (tbl[r].resp[0]) chk($sformatf("tbl%0d_i_rdata", r), i_rdata, tbl[r].rdata);
            if (tbl[r].resp[1]) chk($sformatf("tbl%0d_dr_rdata", r), dr_rdata, tbl[r].rdata);
        end

        // ---------------- write with delayed m_gnt ----------------
        quiet_inputs();
        dw_addr = 32'h40; dw_wdata = 32'h12345678; dw_be = 4'b0110; dw_req = 1;
        tick();
        chk("wr_gnt", gnt, 3'b100);
        dw_req = 0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wr_mreq_c%0d", j), m_req, 1);
            chk($sformatf("wr_fields_c%0d", j), {m_we, m_be, m_addr, m_wdata},
                {1'b1, 4'b0110, 32'h40, 32'h12345678});
            m_gnt = (j == 3);
            tick();
        end
        chk("wr_mreq_drop", m_req, 0);
        chk("wr_done_early", dw_done, 0);
        m_gnt = 0; m_rvalid = 1;
        tick();
        chk("wr_done", {dw_done, dw_err}, 2'b10);
        m_rvalid = 0;
        tick();
        chk("wr_done_width", dw_done, 0);

        // ---------------- contention: all requests held from reset ----------------
        quiet_inputs();
        i_req = 1; dr_req = 1; dw_req = 1; m_gnt = 1; m_rvalid = 1;
        do_reset();
        ngr = 0;
        exp_idx = 0;
        for (int c = 0; c < 40 && ngr < 6; c++) begin
            tick();
            if (gnt != 0) begin
                chk($sformatf("rr_grant%0d", ngr), gnt, 3'b001 << exp_idx);
                exp_idx = (exp_idx + 1) % 3;
                ngr++;
            end
        end
        chk("rr_grant_count", ngr, 6);

        // ---------------- timeout (TIMEOUT=4 instance) ----------------
        quiet_inputs();
        do_reset();
        dr_req = 1;
        tick();
        chk("to_gnt", {to_dr_gnt, to_m_req}, 2'b11);
        dr_req = 0;
        for (int j = 0; j < 4; j++) begin
            m_gnt = (j == 0);
            tick();
            chk($sformatf("to_rvalid_c%0d", j + 1), to_dr_rvalid, (j == 3));
        end
        chk("to_err", {to_dr_err, to_dr_rdata, to_busy}, {1'b1, 32'h0, 1'b0});
        m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
        tick();
        chk("to_late_ignored", {to_dr_rvalid, to_dr_err, to_busy, to_i_rvalid, to_dw_done}, 0);
        m_rvalid = 0;
        tick();
        chk("to_quiet", {to_dr_rvalid, to_dr_err}, 0);

        // ---------------- random traffic vs model ----------------
        quiet_inputs();
        do_reset();
        model_reset();
        reqb = 0; wd_r = 0; be_r = 0;
        for (int k = 0; k < 3; k++) addr_r[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_gnt", gnt, e_gnt);
            chk("rnd_resp", resp, e_resp);
            chk("rnd_err", errv, e_err);
            chk("rnd_mreq_busy", {m_req, busy}, {e_mreq, e_busy});
            chk("rnd_maddr_we", {m_addr, m_we}, {e_maddr, e_mwe});
            if (e_mwe) chk("rnd_wfields", {m_wdata, m_be}, {e_mwdata, e_mbe});
            if (e_resp[0]) chk("rnd_i_rdata", i_rdata, e_rdata);
            if (e_resp[1]) chk("rnd_dr_rdata", dr_rdata, e_rdata);
            for (int k = 0; k < 3; k++) begin
                if (e_gnt[k]) reqb[k] = 0;
                if (!reqb[k] && ($urandom % 4 == 0)) begin
                    reqb[k] = 1;
                    addr_r[k] = $urandom;
                    if (k == 2) begin
                        wd_r = $urandom;
                        be_r = 4'($urandom);
                    end
                end
            end
            {dw_req, dr_req, i_req} = reqb;
            i_addr = addr_r[0]; dr_addr = addr_r[1]; dw_addr = addr_r[2];
            dw_wdata = wd_r; dw_be = be_r;
            m_gnt = ($urandom % 2 == 0);
            m_rvalid = ($urandom % 8 == 0);
            m_rdata = $urandom;
            model_step();
            tick();
        end

        // ---------------- reset mid-WAIT ----------------
        quiet_inputs();
        do_reset();
        i_req = 1; i_addr = 32'h300;
        tick();
        chk("rw_gnt", gnt, 3'b001);
        i_req = 0; m_gnt = 1;
        tick();
        chk("rw_in_wait", {busy, m_req}, 2'b10);
        m_gnt = 0;
        rst = 1'b1;
        #1;
        chk("rw_async_outs", {gnt, resp, errv, m_req, m_we, busy, m_be}, 0);
        chk("rw_async_data", {m_addr, m_wdata, i_rdata}, 0);
        m_rvalid = 1; m_rdata = 32'h99999999;
        @(negedge clk);
        tick();
        chk("rw_no_resp_in_rst", {resp, busy}, 0);
        rst = 1'b0;
        m_rvalid = 0;
        i_req = 1; dr_req = 1;
        tick();
        chk("rw_first_gnt", gnt, 3'b001);
        chk("rw_no_resp_after", resp, 0);
        i_req = 0;
        w = 0;
        tick();
        chk("rw_gnt_width", gnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
